// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default oversampling ratio and mid-bit sample point
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam int OVERSAMPLE_DEF = 16;
  function automatic int mid_bit(input int os);
    return os / 2 - 1;
  endfunction
  localparam int MID_BIT = mid_bit(OVERSAMPLE_DEF);
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with parameterised reset value (clk, rst_n, d -> q)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (clk, rst_n, tick, rxd -> data_out, data_valid, frame_err, busy); UART_RX_PARITY_EN adds even parity and parity_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID = SW'(mid_bit(OVERSAMPLE));
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0] BLAST = 3'(DATA_BITS - 1);
  state_t state, state_d;
  logic [SW-1:0] smp_cnt, smp_cnt_d;
  logic [2:0] bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shreg, shreg_d, data_out_d;
  logic data_valid_d, frame_err_d, rxd_s, at_last, par_bad;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rxd), .q(rxd_s));
  assign at_last = tick && smp_cnt == LAST;
  assign busy = state != IDLE;
`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_d, parity_err_d;
  assign par_bad = ^{shreg, par_bit};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bit    <= par_bit_d;
      parity_err <= parity_err_d;
    end
`else
  assign par_bad = 1'b0;
`endif
  always_comb begin
    state_d      = state;
    smp_cnt_d    = smp_cnt;
    bit_idx_d    = bit_idx;
    shreg_d      = shreg;
    data_out_d   = data_out;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit;
    parity_err_d = 1'b0;
`endif
    case (state)
      IDLE: if (!rxd_s) begin
        state_d   = START;
        smp_cnt_d = '0;
      end
      START: if (tick) begin
        smp_cnt_d = smp_cnt == MID ? '0 : smp_cnt + 1'b1;
        bit_idx_d = '0;
        state_d   = smp_cnt != MID ? START : rxd_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        smp_cnt_d = at_last ? '0 : smp_cnt + 1'b1;
        if (at_last) begin
          shreg_d   = {rxd_s, shreg[DATA_BITS-1:1]};
          bit_idx_d = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          state_d   = bit_idx == BLAST ? PARITY : DATA;
`else
          state_d   = bit_idx == BLAST ? STOP : DATA;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        smp_cnt_d = at_last ? '0 : smp_cnt + 1'b1;
        par_bit_d = at_last ? rxd_s : par_bit;
        state_d   = at_last ? STOP : PARITY;
      end
`endif
      STOP: if (tick) begin
        smp_cnt_d = at_last ? '0 : smp_cnt + 1'b1;
        if (at_last) begin
          state_d      = rxd_s ? IDLE : BREAK;
          frame_err_d  = !rxd_s;
          data_valid_d = rxd_s && !par_bad;
          data_out_d   = rxd_s && !par_bad ? shreg : data_out;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad;
`endif
        end
      end
      BREAK: state_d = rxd_s ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      smp_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      smp_cnt    <= smp_cnt_d;
      bit_idx    <= bit_idx_d;
      shreg      <= shreg_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      frame_err  <= frame_err_d;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

16x-oversampling UART receiver that consumes the `tick` strobe produced by the baud generator and turns the serial `rxd` line into parallel bytes. It sits directly downstream of the baud generator, with the same clock, reset and `tick` wiring. It feeds the ASCII/character-handling logic through a one-cycle `data_valid` strobe.

## Interface
- `DATA_BITS`, 8: payload bits per frame, sent LSB first; legal range 5–8.
- `OVERSAMPLE`, 16: `tick` pulses per bit period; must match the baud generator.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-`clk`-wide strobe at OVERSAMPLE × baud.
- `rxd`  in  1  asynchronous serial input; idle high.
- `data_out`  out  DATA_BITS  last good byte; held until the next good frame.
- `data_valid`  out  1  one-cycle strobe when `data_out` updates.
- `frame_err`  out  1  one-cycle strobe when the stop bit is sampled low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rxd` passes through a 2-FF synchronizer before any use; its reset value is 1.
- States: IDLE, START, DATA, (PARITY), STOP, BREAK.
- Counters:
  - `smp_cnt` is log2(OVERSAMPLE) bits wide and advances only on `tick`.
  - `bit_idx` is 3 bits wide.
- Transitions:
  - **IDLE:** synced `rxd` = 0 → START, with `smp_cnt` = 0. `tick` is ignored in IDLE.
  - **START:** at `smp_cnt` = OVERSAMPLE/2−1 (mid start bit):
    - `rxd` = 0 → DATA, `smp_cnt` = 0, `bit_idx` = 0;
    - `rxd` = 1 → IDLE (glitch rejected, no strobe).
  - **DATA:** at `smp_cnt` = OVERSAMPLE−1, sample `rxd` into the shift register MSB and shift right, then `bit_idx`++ and `smp_cnt` = 0. After DATA_BITS samples → STOP, or → PARITY when the parity feature is compiled in.
  - **STOP:** at `smp_cnt` = OVERSAMPLE−1:
    - `rxd` = 1 → load `data_out` and pulse `data_valid`, then go to IDLE;
    - `rxd` = 0 → pulse `frame_err`, leave `data_out` unchanged, go to BREAK.
  - **BREAK:** wait for synced `rxd` = 1, then go to IDLE. This prevents a held-low line from being read as repeated 0x00 frames.
- Returning to IDLE at mid stop bit allows a back-to-back start bit to be detected with no gap.
- `data_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `frame_err` = 0, `busy` = 0, state = IDLE, both counters 0.
- Reset asserted mid-frame aborts the frame immediately, with no strobe, and all outputs return to their reset values.
- The `rxd` falling edge reaches the FSM 2 `clk` cycles later, because of the synchronizer.
- `data_valid` / `frame_err` assert on the `clk` cycle after the `tick` that samples the stop bit, and last exactly 1 cycle.
- `busy` rises 1 cycle after IDLE→START and falls in the same cycle the strobe asserts.
- Frame latency, from the start-bit edge to `data_valid`: about (OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE) ticks + 3 `clk`.
- `tick` in the same cycle as a state transition is consumed by the new state only from the next `tick` onward.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - adds the PARITY state after DATA, sampled at `smp_cnt` = OVERSAMPLE−1 (even parity);
  - adds output `parity_err` (1 bit, reset 0, one-cycle strobe coincident with the stop-bit decision);
  - on a parity mismatch with a good stop bit: `parity_err` pulses, `data_valid` does not pulse, and `data_out` is not updated.
- **`UART_RX_PARITY_EN` undefined:** no PARITY state, no `parity_err` port, and the frame is 8N1 (with DATA_BITS = 8).

## Structure
- `uart_pkg` holds:
  - the state encoding constants (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the OVERSAMPLE default;
  - the mid-bit constant OVERSAMPLE/2−1.
- The baud generator uses the same package.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with a parameterised reset value (1 here).

## Test plan
- **Good frame:** 0x55 sent at 19200 baud with a 50 MHz `clk` and baud generator ticks → `data_out` = 0x55, `data_valid` high for exactly 1 cycle, `frame_err` = 0.
- **Back-to-back frames:** 0xA3 then 0x3C, with the next start bit immediately after the stop bit → two `data_valid` pulses carrying 0xA3 then 0x3C.
- **Glitch rejection:** `rxd` low for 4 ticks, then high → no strobe, `busy` returns to 0, FSM back in IDLE.
- **Bad stop bit:** 0x7E sent with the stop bit = 0, then the line held low for 3 bit times → a single `frame_err` pulse, `data_out` keeps its previous value, and no further frames until `rxd` returns high.
- **Reset mid-frame:** `rst_n` asserted during bit 4 of 0xFF → all outputs 0 immediately; a following frame of 0x12 is received correctly.
- **Parity (`UART_RX_PARITY_EN`):** 0x01 with parity bit 0 → `parity_err` pulses, no `data_valid`; with parity bit 1 → `data_out` = 0x01 and `data_valid` pulses.
